// File: rtl/muldiv_pipe_pkg.sv
// Shared backend definitions for the muldiv pipe: field widths, the one-hot
// muldiv operation bit positions and the ROB age compare.
package muldiv_pipe_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned MULDIV_TYPE_W = 13;
    localparam int unsigned ROBID_W       = 7;
    localparam int unsigned ROB_IDX_W     = ROBID_W - 1;
    localparam int unsigned PRD_W         = 6;

    // Bit positions inside the one-hot muldiv_type vector.
    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7,
        MD_MULW   = 4'd8,
        MD_DIVW   = 4'd9,
        MD_DIVUW  = 4'd10,
        MD_REMW   = 4'd11,
        MD_REMUW  = 4'd12
    } md_op_e;

    typedef logic [ROBID_W-1:0] robid_t;

    // True when a is strictly younger than f; the top bit is the ROB wrap flag.
    function automatic logic rob_younger(input robid_t a, input robid_t f);
        if (a[ROBID_W-1] == f[ROBID_W-1])
            return a[ROB_IDX_W-1:0] > f[ROB_IDX_W-1:0];
        return a[ROB_IDX_W-1:0] < f[ROB_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/muldiv_pipe_muldiv.sv
// Combinational muldiv unit: RV64M multiply/divide selected by a one-hot type,
// results OR-combined so a clear type vector yields zero.
module muldiv_pipe_muldiv
    import muldiv_pipe_pkg::*;
(
    input  logic [XLEN-1:0]          src1,
    input  logic [XLEN-1:0]          src2,
    input  logic [MULDIV_TYPE_W-1:0] muldiv_type,
    output logic [XLEN-1:0]          result
);

    localparam int unsigned HALF = XLEN / 2;

    logic                   mul_a_signed;
    logic                   mul_b_signed;
    logic signed [XLEN:0]   mul_a;
    logic signed [XLEN:0]   mul_b;
    logic [2*XLEN-1:0]      prod;

    // One multiplier serves every variant: operands widened by one bit with
    // the sign or a zero, so the low 128 product bits are exact.
    assign mul_a_signed = muldiv_type[MD_MULH] | muldiv_type[MD_MULHSU];
    assign mul_b_signed = muldiv_type[MD_MULH];
    assign mul_a        = {mul_a_signed & src1[XLEN-1], src1};
    assign mul_b        = {mul_b_signed & src2[XLEN-1], src2};
    assign prod         = 128'(mul_a) * 128'(mul_b);

    logic            div_signed;
    logic            div_word;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] da;
    logic [XLEN-1:0] db;
    logic [XLEN-1:0] ua;
    logic [XLEN-1:0] ub;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    assign div_signed = muldiv_type[MD_DIV] | muldiv_type[MD_REM] |
                        muldiv_type[MD_DIVW] | muldiv_type[MD_REMW];
    assign div_word   = muldiv_type[MD_DIVW] | muldiv_type[MD_DIVUW] |
                        muldiv_type[MD_REMW] | muldiv_type[MD_REMUW];

    // Signed overflow needs no special case: the magnitude path already
    // returns the dividend as quotient and zero as remainder.
    always_comb begin
        da  = src1;
        db  = src2;
        quo = '1;
        rem = '0;
        if (div_word) begin
            da = {{HALF{div_signed & src1[HALF-1]}}, src1[HALF-1:0]};
            db = {{HALF{div_signed & src2[HALF-1]}}, src2[HALF-1:0]};
        end
        a_neg = div_signed & da[XLEN-1];
        b_neg = div_signed & db[XLEN-1];
        ua    = a_neg ? -da : da;
        ub    = b_neg ? -db : db;
        if (ub == '0) begin
            quo = '1;
            rem = da;
        end else begin
            quo = (a_neg ^ b_neg) ? -(ua / ub) : (ua / ub);
            rem = a_neg ? -(ua % ub) : (ua % ub);
        end
    end

    always_comb begin
        result = '0;
        if (muldiv_type[MD_MUL])    result |= prod[XLEN-1:0];
        if (muldiv_type[MD_MULH])   result |= prod[2*XLEN-1:XLEN];
        if (muldiv_type[MD_MULHSU]) result |= prod[2*XLEN-1:XLEN];
        if (muldiv_type[MD_MULHU])  result |= prod[2*XLEN-1:XLEN];
        if (muldiv_type[MD_DIV])    result |= quo;
        if (muldiv_type[MD_DIVU])   result |= quo;
        if (muldiv_type[MD_REM])    result |= rem;
        if (muldiv_type[MD_REMU])   result |= rem;
        if (muldiv_type[MD_MULW])   result |= {{HALF{prod[HALF-1]}}, prod[HALF-1:0]};
        if (muldiv_type[MD_DIVW])   result |= {{HALF{quo[HALF-1]}}, quo[HALF-1:0]};
        if (muldiv_type[MD_DIVUW])  result |= {{HALF{quo[HALF-1]}}, quo[HALF-1:0]};
        if (muldiv_type[MD_REMW])   result |= {{HALF{rem[HALF-1]}}, rem[HALF-1:0]};
        if (muldiv_type[MD_REMUW])  result |= {{HALF{rem[HALF-1]}}, rem[HALF-1:0]};
    end

endmodule

// File: rtl/muldiv_pipe.sv
// Fixed three-stage muldiv pipe with a global stall on writeback backpressure
// and age-based flush kills in every stage.
module muldiv_pipe
    import muldiv_pipe_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [XLEN-1:0]          issue_src1,
    input  logic [XLEN-1:0]          issue_src2,
    input  logic [MULDIV_TYPE_W-1:0] issue_muldiv_type,
    input  logic [ROBID_W-1:0]       issue_robid,
    input  logic [PRD_W-1:0]         issue_prd,
    input  logic                     flush_valid,
    input  logic [ROBID_W-1:0]       flush_robid,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [XLEN-1:0]          wb_result,
    output logic [ROBID_W-1:0]       wb_robid,
    output logic [PRD_W-1:0]         wb_prd
);

    localparam int unsigned LATENCY = 3;

    // vld[0] is S1, vld[LATENCY-1] is the output stage.
    logic [LATENCY-1:0]       vld;
    logic [LATENCY-1:0]       kill;
    logic                     advance;
    logic                     issue_fire;

    logic [XLEN-1:0]          s1_src1;
    logic [XLEN-1:0]          s1_src2;
    logic [MULDIV_TYPE_W-1:0] s1_type;
    logic [ROBID_W-1:0]       s1_robid;
    logic [PRD_W-1:0]         s1_prd;
    logic [XLEN-1:0]          s2_result;
    logic [ROBID_W-1:0]       s2_robid;
    logic [PRD_W-1:0]         s2_prd;
    logic [XLEN-1:0]          s3_result;
    logic [ROBID_W-1:0]       s3_robid;
    logic [PRD_W-1:0]         s3_prd;
    logic [XLEN-1:0]          md_result;

    assign advance     = !(vld[LATENCY-1] && !wb_ready);
    assign issue_ready = reset_n && advance && !flush_valid;
    assign issue_fire  = issue_valid && issue_ready;

    assign kill[0] = flush_valid && rob_younger(s1_robid, flush_robid);
    assign kill[1] = flush_valid && rob_younger(s2_robid, flush_robid);
    assign kill[2] = flush_valid && rob_younger(s3_robid, flush_robid);

    muldiv_pipe_muldiv u_muldiv (
        .src1        (s1_src1),
        .src2        (s1_src2),
        .muldiv_type (s1_type),
        .result      (md_result)
    );

    // Killed entries are masked before shifting so they never reach the
    // next stage, even when flush and advance coincide.
    always_ff @(posedge clock) begin
        if (!reset_n)
            vld <= '0;
        else if (advance)
            vld <= {vld[LATENCY-2:0] & ~kill[LATENCY-2:0], issue_fire};
        else
            vld <= vld & ~kill;
    end

    always_ff @(posedge clock) begin
        if (advance) begin
            if (issue_fire) begin
                s1_src1  <= issue_src1;
                s1_src2  <= issue_src2;
                s1_type  <= issue_muldiv_type;
                s1_robid <= issue_robid;
                s1_prd   <= issue_prd;
            end
            s2_result <= md_result;
            s2_robid  <= s1_robid;
            s2_prd    <= s1_prd;
            s3_result <= s2_result;
            s3_robid  <= s2_robid;
            s3_prd    <= s2_prd;
        end
    end

    assign wb_valid  = vld[LATENCY-1];
    assign wb_result = s3_result;
    assign wb_robid  = s3_robid;
    assign wb_prd    = s3_prd;

endmodule

// File: tb/tb_muldiv_pipe.sv
// Directed bench for muldiv_pipe: latency, throughput, stall, flush kills,
// ROB wrap-around age compare and reset during a stall.
module tb_muldiv_pipe;
    import muldiv_pipe_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [63:0] issue_src1;
    logic [63:0] issue_src2;
    logic [12:0] issue_muldiv_type;
    logic [6:0]  issue_robid;
    logic [5:0]  issue_prd;
    logic        flush_valid;
    logic [6:0]  flush_robid;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_result;
    logic [6:0]  wb_robid;
    logic [5:0]  wb_prd;

    int n_cmp = 0;
    int n_err = 0;

    logic [12:0] bt [4];
    logic [63:0] ba [4];
    logic [63:0] bb [4];
    logic [63:0] be [4];

    muldiv_pipe dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_src1        (issue_src1),
        .issue_src2        (issue_src2),
        .issue_muldiv_type (issue_muldiv_type),
        .issue_robid       (issue_robid),
        .issue_prd         (issue_prd),
        .flush_valid       (flush_valid),
        .flush_robid       (flush_robid),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_result         (wb_result),
        .wb_robid          (wb_robid),
        .wb_prd            (wb_prd)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [12:0] oh(input md_op_e op);
        return 13'd1 << op;
    endfunction

    task automatic drive(input logic [12:0] t, input logic [63:0] a, input logic [63:0] b,
                         input logic [6:0] r, input logic [5:0] p);
        issue_valid       = 1'b1;
        issue_muldiv_type = t;
        issue_src1        = a;
        issue_src2        = b;
        issue_robid       = r;
        issue_prd         = p;
    endtask

    // Four back-to-back issues; op j must appear exactly three edges after issue.
    task automatic burst(input logic [6:0] rbase);
        for (int k = 0; k < 7; k++) begin
            if (k < 4) drive(bt[k], ba[k], bb[k], rbase + 7'(k), 6'(k));
            else issue_valid = 1'b0;
            #1;
            check("burst_issue_ready", {63'd0, issue_ready}, 64'd1);
            cyc();
            if (k >= 2 && k <= 5) begin
                check("burst_wb_valid", {63'd0, wb_valid}, 64'd1);
                check("burst_result", wb_result, be[k-2]);
                check("burst_robid", {57'd0, wb_robid}, {57'd0, rbase + 7'(k-2)});
            end else begin
                check("burst_idle", {63'd0, wb_valid}, 64'd0);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; issue_valid = 1'b0; issue_src1 = '0; issue_src2 = '0;
        issue_muldiv_type = '0; issue_robid = '0; issue_prd = '0;
        flush_valid = 1'b0; flush_robid = '0; wb_ready = 1'b1;
        cyc(); cyc();
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_issue_ready", {63'd0, issue_ready}, 64'd0);
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", {63'd0, issue_ready}, 64'd1);

        // Single MUL 7*6 with exact three-cycle latency
        drive(oh(MD_MUL), 64'd7, 64'd6, 7'h05, 6'd9);
        cyc(); issue_valid = 1'b0;
        check("mul_lat1", {63'd0, wb_valid}, 64'd0);
        cyc();
        check("mul_lat2", {63'd0, wb_valid}, 64'd0);
        cyc();
        check("mul_valid", {63'd0, wb_valid}, 64'd1);
        check("mul_result", wb_result, 64'd42);
        check("mul_robid", {57'd0, wb_robid}, 64'h05);
        check("mul_prd", {58'd0, wb_prd}, 64'd9);
        cyc();
        check("mul_retired", {63'd0, wb_valid}, 64'd0);

        // Throughput: DIVU 100/7, 9/3, 0/1, 64/8
        for (int i = 0; i < 4; i++) bt[i] = oh(MD_DIVU);
        ba[0] = 64'd100; bb[0] = 64'd7; be[0] = 64'd14;
        ba[1] = 64'd9;   bb[1] = 64'd3; be[1] = 64'd3;
        ba[2] = 64'd0;   bb[2] = 64'd1; be[2] = 64'd0;
        ba[3] = 64'd64;  bb[3] = 64'd8; be[3] = 64'd8;
        burst(7'h20);

        // Mixed ops: MULHU high word, signed REM, DIVU by zero, MULW sign-extend
        bt[0] = oh(MD_MULHU); ba[0] = 64'h8000_0000_0000_0000; bb[0] = 64'd4; be[0] = 64'd2;
        bt[1] = oh(MD_REM);   ba[1] = 64'hFFFF_FFFF_FFFF_FFF9; bb[1] = 64'd2; be[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        bt[2] = oh(MD_DIVU);  ba[2] = 64'd123; bb[2] = 64'd0; be[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        bt[3] = oh(MD_MULW);  ba[3] = 64'h8000_0000; bb[3] = 64'd1; be[3] = 64'hFFFF_FFFF_8000_0000;
        burst(7'h30);

        // Stall: three ops in flight, wb_ready low for five cycles
        drive(oh(MD_MUL), 64'd3, 64'd5, 7'h50, 6'd1); cyc();
        drive(oh(MD_MUL), 64'd2, 64'd11, 7'h51, 6'd2); cyc();
        drive(oh(MD_MUL), 64'd16, 64'd16, 7'h52, 6'd3); wb_ready = 1'b0; cyc();
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_issue_ready", {63'd0, issue_ready}, 64'd0);
            check("stall_wb_valid", {63'd0, wb_valid}, 64'd1);
            check("stall_result", wb_result, 64'd15);
            check("stall_robid", {57'd0, wb_robid}, 64'h50);
            cyc();
        end
        wb_ready = 1'b1;
        #1;
        check("stall_rel0_valid", {63'd0, wb_valid}, 64'd1);
        check("stall_rel0_result", wb_result, 64'd15);
        cyc();
        check("stall_rel1_valid", {63'd0, wb_valid}, 64'd1);
        check("stall_rel1_result", wb_result, 64'd22);
        check("stall_rel1_robid", {57'd0, wb_robid}, 64'h51);
        cyc();
        check("stall_rel2_valid", {63'd0, wb_valid}, 64'd1);
        check("stall_rel2_result", wb_result, 64'd256);
        cyc();
        check("stall_drained", {63'd0, wb_valid}, 64'd0);

        // Flush at 0x10 with 0x10/0x11/0x12 in S3/S2/S1
        drive(oh(MD_MUL), 64'd1, 64'd1, 7'h10, 6'd4); cyc();
        drive(oh(MD_MUL), 64'd2, 64'd1, 7'h11, 6'd5); cyc();
        drive(oh(MD_MUL), 64'd3, 64'd1, 7'h12, 6'd6); cyc();
        drive(oh(MD_MUL), 64'd4, 64'd1, 7'h13, 6'd7);
        flush_valid = 1'b1; flush_robid = 7'h10;
        #1;
        check("flush_issue_ready", {63'd0, issue_ready}, 64'd0);
        check("flush_keep_valid", {63'd0, wb_valid}, 64'd1);
        check("flush_keep_robid", {57'd0, wb_robid}, 64'h10);
        check("flush_keep_result", wb_result, 64'd1);
        cyc();
        flush_valid = 1'b0; issue_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush_killed", {63'd0, wb_valid}, 64'd0);
            cyc();
        end

        // Wrap-around: 0x41 stalled in S3 and 0x3E in S2, flush at 0x3F
        drive(oh(MD_MUL), 64'd2, 64'd3, 7'h41, 6'd10); cyc();
        drive(oh(MD_DIV), 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 7'h3E, 6'd11); wb_ready = 1'b0; cyc();
        issue_valid = 1'b0; cyc();
        check("wrap_pre_valid", {63'd0, wb_valid}, 64'd1);
        check("wrap_pre_robid", {57'd0, wb_robid}, 64'h41);
        flush_valid = 1'b1; flush_robid = 7'h3F;
        #1;
        check("wrap_issue_ready", {63'd0, issue_ready}, 64'd0);
        cyc();
        flush_valid = 1'b0;
        #1;
        check("wrap_killed", {63'd0, wb_valid}, 64'd0);
        check("wrap_ready_after", {63'd0, issue_ready}, 64'd1);
        cyc();
        check("wrap_keep_valid", {63'd0, wb_valid}, 64'd1);
        check("wrap_keep_robid", {57'd0, wb_robid}, 64'h3E);
        check("wrap_keep_result", wb_result, 64'hFFFF_FFFF_FFFF_FFFA);
        check("wrap_keep_prd", {58'd0, wb_prd}, 64'd11);
        wb_ready = 1'b1;
        cyc();
        check("wrap_drained", {63'd0, wb_valid}, 64'd0);

        // Reset for one cycle while stalled with three valid stages
        drive(oh(MD_MUL), 64'd1, 64'd5, 7'h60, 6'd1); cyc();
        drive(oh(MD_MUL), 64'd2, 64'd5, 7'h61, 6'd2); cyc();
        drive(oh(MD_MUL), 64'd3, 64'd5, 7'h62, 6'd3); wb_ready = 1'b0; cyc();
        issue_valid = 1'b0;
        check("rms_pre_valid", {63'd0, wb_valid}, 64'd1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1; wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rms_no_wb", {63'd0, wb_valid}, 64'd0);
            cyc();
        end
        drive(oh(MD_MUL), 64'd3, 64'd3, 7'h63, 6'd12); cyc();
        issue_valid = 1'b0; cyc(); cyc();
        check("rms_new_valid", {63'd0, wb_valid}, 64'd1);
        check("rms_new_result", wb_result, 64'd9);
        check("rms_new_robid", {57'd0, wb_robid}, 64'h63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_pipe.md
MULDIV_PIPE -- requirements
Module: muldiv_pipe

Interface
REQ-001 SHALL have parameter LATENCY, default 3: fixed issue-to-result cycles with no backpressure; value is not overridable.
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port issue_valid, input, 1: issue queue presents a muldiv instruction.
REQ-005 SHALL have port issue_ready, output, 1: pipe accepts the instruction this cycle.
REQ-006 SHALL have ports issue_src1 and issue_src2, input, 64 each: operands.
REQ-007 SHALL have port issue_muldiv_type, input, 13: one-hot op select, same encoding the muldiv unit consumes.
REQ-008 SHALL have port issue_robid, input, 7: bit 6 is wrap flag, bits 5:0 are ROB index.
REQ-009 SHALL have port issue_prd, input, 6: physical destination register.
REQ-010 SHALL have ports flush_valid, input, 1, and flush_robid, input, 7: redirect that kills instructions strictly younger than flush_robid.
REQ-011 SHALL have ports wb_valid, output, 1, and wb_ready, input, 1: writeback handshake.
REQ-012 SHALL have ports wb_result, output, 64; wb_robid, output, 7; and wb_prd, output, 6: writeback payload.

Function
REQ-013 SHALL implement three stages: S1 holds operands, type, robid and prd; S2 holds the muldiv result plus tags; S3 is the output register driving wb_*.
REQ-014 SHALL define an issue transfer as issue_valid && issue_ready, capturing all issue_* fields into S1.
REQ-015 SHALL define advance = !(s3_valid && !wb_ready); when advance is 1, S1 moves to S2, S2 to S3, and S3 retires or is refilled.
REQ-016 SHALL drive issue_ready = advance && !flush_valid.
REQ-017 SHALL hold all three stages unchanged when advance is 0 (global stall), except for flush kills.
REQ-018 SHALL, absent stall, present an instruction accepted in cycle N on wb_valid in cycle N+3.
REQ-019 SHALL drive wb_valid = s3_valid and keep the wb_* payload stable while wb_valid && !wb_ready.
REQ-020 SHALL compute S2 data using the muldiv unit's one-hot selection semantics, with S1 registered values as inputs.
REQ-021 SHALL treat robid A as younger than F when (A[6]==F[6] && A[5:0]>F[5:0]) or (A[6]!=F[6] && A[5:0]<F[5:0]).
REQ-022 SHALL, on flush_valid, clear the valid bit that cycle of every stage whose robid is younger than flush_robid, whether or not the pipe is stalled.
REQ-023 SHALL NOT kill a stage whose robid equals flush_robid or is older.
REQ-024 SHALL apply both the kill and the advance in a cycle with flush_valid and advance, so that killed entries do not appear in the next stage.
REQ-025 SHALL let wb_valid drop without handshake when the S3 entry is killed by flush; this is the sole exception to REQ-019.
REQ-026 SHALL produce a bubble in a stage when its predecessor is invalid and advance is 1.
REQ-027 SHALL process back-to-back issues at full throughput, one per cycle.

Reset
REQ-028 SHALL, with reset_n low at a clock edge, clear s1_valid, s2_valid and s3_valid to 0; wb_valid is 0 and issue_ready is 0 during reset.
REQ-029 SHALL leave data and tag registers unreset; they are don't-care while their valid bit is 0.
REQ-030 SHALL, on reset during a stall, discard all in-flight entries with no writeback.

Structure
REQ-031 SHALL place the ROB-age compare function, the 13-bit muldiv type width and the robid/prd widths in the shared backend package.
REQ-032 SHALL instantiate the existing muldiv unit once as the only sub-module, between S1 and S2.

Verification
REQ-033 SHALL cover single MUL: src1=7, src2=6, robid=0x05, wb_ready=1 -> wb_valid exactly 3 cycles later, result=42, robid=0x05.
REQ-034 SHALL cover throughput: four back-to-back DIVU ops (100/7, 9/3, 0/1, 64/8) -> four consecutive wb_valid cycles with results 14, 3, 0, 8 in order.
REQ-035 SHALL cover stall: hold wb_ready=0 for 5 cycles with 3 ops in flight -> issue_ready=0, S3 payload stable, then all 3 retire in order once wb_ready=1.
REQ-036 SHALL cover flush: ops with robid 0x10, 0x11, 0x12 in S3/S2/S1, flush_robid=0x10 -> only 0x10 writes back; issue_ready=0 in the flush cycle.
REQ-037 SHALL cover wrap-around: in-flight robid 0x41 and flush_robid 0x3F -> 0x41 is killed; in-flight 0x3E is kept.
REQ-038 SHALL cover reset mid-stall: reset_n low for one cycle with 3 valid stages -> no wb_valid afterwards until a new issue.
